mc_control_fsm: RTL and testbench

- Multi-cycle control sequencer for the RV32I datapath.
- Replaces the single-cycle combinational control. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath control input: register write, ALU source selects, ALU op, byte write enables and read enable.
- Also drives PC/IR update strobes.
- Detects illegal and misaligned operations, halts on ECALL/EBREAK, and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/mc_alu_decode.sv | 38 +++
 rtl/mc_control_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: opcodes, FSM states,
// mux select codes, ALU control codes and the load/store alignment helpers.
package mc_ctrl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  typedef enum logic [1:0] {PcPlus4 = 2'd0, PcRel = 2'd1, PcJalr = 2'd2} pc_src_e;

  typedef enum logic [1:0] {WbAlu = 2'd0, WbMem = 2'd1, WbPc4 = 2'd2} wb_sel_e;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } alu_op_e;

  // funct3[1:0] gives the access size for both loads and stores.
  function automatic logic mem_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU control decode for OP/OP-IMM/LUI; flags funct7[5] misuse.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_op,
  output logic       illegal
);

  logic is_op;
  logic is_arith;

  assign is_op    = (opcode == OP);
  assign is_arith = is_op || (opcode == OP_IMM);

  always_comb begin
    alu_op  = AluAdd;
    illegal = 1'b0;
    if (is_arith) begin
      // For OP-IMM, funct7[5] is an immediate bit except on shifts.
      case (funct3)
        3'b000: alu_op = (is_op && funct7_b5) ? AluSub : AluAdd;
        3'b001: begin alu_op = AluSll;  illegal = funct7_b5;          end
        3'b010: begin alu_op = AluSlt;  illegal = is_op && funct7_b5; end
        3'b011: begin alu_op = AluSltu; illegal = is_op && funct7_b5; end
        3'b100: begin alu_op = AluXor;  illegal = is_op && funct7_b5; end
        3'b101: alu_op = funct7_b5 ? AluSra : AluSrl;
        3'b110: begin alu_op = AluOr;   illegal = is_op && funct7_b5; end
        default: begin alu_op = AluAnd; illegal = is_op && funct7_b5; end
      endcase
    end else if (opcode == LUI) begin
      alu_op = AluPassB;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with trap detection,
// halt on ECALL/EBREAK and a retired-instruction counter.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit          RESET_START = 1'b0,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          instruction,
  input  logic                 branch_cond,
  input  logic [1:0]           mem_addr_lo,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write_en,
  output logic                 dest_reg_sel,
  output logic                 alu_src_A,
  output logic                 alu_src_B,
  output logic [3:0]           alu_op,
  output logic [3:0]           mem_write_en,
  output logic                 read_enable,
  output logic [1:0]           wb_sel,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_e                 state;
  logic                   illegal_q;
  logic [INSTRET_W-1:0]   instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  logic is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr;
  logic is_lui, is_auipc, is_fence;
  assign is_op     = (opcode == OP);
  assign is_op_imm = (opcode == OP_IMM);
  assign is_load   = (opcode == LOAD);
  assign is_store  = (opcode == STORE);
  assign is_branch = (opcode == BRANCH);
  assign is_jal    = (opcode == JAL);
  assign is_jalr   = (opcode == JALR);
  assign is_lui    = (opcode == LUI);
  assign is_auipc  = (opcode == AUIPC);
  assign is_fence  = (opcode == FENCE);

  logic [3:0] dec_alu_op;
  logic       dec_illegal;

  mc_alu_decode u_alu_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (funct7[5]),
    .alu_op    (dec_alu_op),
    .illegal   (dec_illegal)
  );

  logic funct7_rsvd, is_illegal, is_sys_halt, misaligned, retire;
  // Only funct7[5] may ever be set in a legal R-type or shift-immediate.
  assign funct7_rsvd = |(funct7 & 7'b1011111);
  assign misaligned  = (is_load || is_store) && mem_misaligned(funct3, mem_addr_lo);
  assign retire = ((state == StExec) && (is_branch || is_jal || is_jalr || is_fence)) ||
                  ((state == StMem) && is_store) || (state == StWb);

  always_comb begin
    is_illegal  = 1'b0;
    is_sys_halt = 1'b0;
    case (opcode)
      OP:               is_illegal = dec_illegal || funct7_rsvd;
      OP_IMM:           is_illegal = dec_illegal || ((funct3[1:0] == 2'b01) && funct7_rsvd);
      LOAD:             is_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      STORE:            is_illegal = funct3[2] || (funct3[1:0] == 2'b11);
      BRANCH:           is_illegal = (funct3[2:1] == 2'b01);
      JALR:             is_illegal = (funct3 != 3'b000);
      FENCE:            is_illegal = (funct3[2:1] != 2'b00);
      JAL, LUI, AUIPC:  is_illegal = 1'b0;
      SYSTEM: begin
        // Only ECALL and EBREAK are recognised; CSR accesses trap.
        is_sys_halt = (instruction[31:7] == 25'h0) || (instruction[31:7] == 25'h2000);
        is_illegal  = !is_sys_halt;
      end
      default:          is_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      unique case (state)
        StIdle:   if (start || RESET_START) state <= StFetch;
        StFetch:  state <= StDecode;
        StDecode: begin
          if (is_illegal) begin
            state     <= StHalt;
            illegal_q <= 1'b1;
          end else if (is_sys_halt) begin
            state <= StHalt;
          end else begin
            state <= StExec;
          end
        end
        StExec: begin
          if (misaligned) begin
            state     <= StHalt;
            illegal_q <= 1'b1;
          end else if (is_load || is_store) begin
            state <= StMem;
          end else if (is_op || is_op_imm || is_lui || is_auipc) begin
            state <= StWb;
          end else begin
            state <= StFetch;
          end
        end
        StMem:    state <= is_store ? StFetch : StWb;
        StWb:     state <= StFetch;
        default:  state <= StHalt;
      endcase
      if (retire) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PcPlus4;
    reg_write_en = 1'b0;
    dest_reg_sel = 1'b0;
    alu_src_A    = 1'b0;
    alu_src_B    = 1'b0;
    alu_op       = AluAdd;
    mem_write_en = 4'b0000;
    read_enable  = 1'b0;
    wb_sel       = WbAlu;
    // ALU controls stay put from EXEC through MEM/WB so the result remains valid.
    if (state inside {StExec, StMem, StWb}) begin
      if (is_op) begin
        alu_op = dec_alu_op;
      end else if (is_op_imm) begin
        alu_src_B = 1'b1;
        alu_op    = dec_alu_op;
      end else if (is_lui) begin
        alu_src_B = 1'b1;
        alu_op    = AluPassB;
      end else if (is_auipc || is_branch) begin
        alu_src_A = 1'b1;
        alu_src_B = 1'b1;
      end else if (is_load || is_store || is_jalr) begin
        alu_src_B = 1'b1;
      end
    end
    unique case (state)
      StFetch: ir_write = 1'b1;
      StExec: begin
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_cond ? PcRel : PcPlus4;
        end else if (is_jal || is_jalr) begin
          reg_write_en = 1'b1;
          dest_reg_sel = 1'b1;
          wb_sel       = WbPc4;
          pc_write     = 1'b1;
          pc_src       = is_jal ? PcRel : PcJalr;
        end else if (is_fence) begin
          pc_write = 1'b1;
        end
      end
      StMem: begin
        if (is_store) begin
          mem_write_en = store_strobe(funct3, mem_addr_lo);
          pc_write     = 1'b1;
        end else begin
          read_enable = 1'b1;
        end
      end
      StWb: begin
        reg_write_en = 1'b1;
        dest_reg_sel = 1'b1;
        wb_sel       = is_load ? WbMem : WbAlu;
        pc_write     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state != StIdle) && (state != StHalt);
  assign halted  = (state == StHalt);
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-instruction-class cycle walks with hand-computed
// control values, reset abort, traps and halt behaviour.
module tb_mc_control_fsm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] instruction;
  logic        branch_cond;
  logic [1:0]  mem_addr_lo;
  logic        ir_write, pc_write, reg_write_en, dest_reg_sel, alu_src_A, alu_src_B;
  logic        read_enable, busy, halted, illegal;
  logic [1:0]  pc_src, wb_sel;
  logic [3:0]  alu_op, mem_write_en;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = 0;

  wire [18:0] ctl = {ir_write, pc_write, pc_src, reg_write_en, dest_reg_sel, alu_src_A,
                     alu_src_B, alu_op, mem_write_en, read_enable, wb_sel};

  mc_control_fsm #(
    .RESET_START (1'b0),
    .INSTRET_W   (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .instruction  (instruction),
    .branch_cond  (branch_cond),
    .mem_addr_lo  (mem_addr_lo),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write_en (reg_write_en),
    .dest_reg_sel (dest_reg_sel),
    .alu_src_A    (alu_src_A),
    .alu_src_B    (alu_src_B),
    .alu_op       (alu_op),
    .mem_write_en (mem_write_en),
    .read_enable  (read_enable),
    .wb_sel       (wb_sel),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reset, then start: leaves the DUT in FETCH with the counter cleared.
  task automatic restart();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    exp_instret = 0;
    pulse_start();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; instruction = 32'h0; branch_cond = 1'b0; mem_addr_lo = 2'd0;
    tick(); tick();
    checks++; if (ctl !== 19'h0) begin errors++; $display("FAIL reset_ctl got %h exp 0", ctl); end
    checks++; if ({busy, halted, illegal} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b exp 000", {busy, halted, illegal});
    end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
    rst = 1'b1;
    tick(); tick();
    checks++; if ({busy, ir_write} !== 2'b00) begin
      errors++; $display("FAIL idle_wait got %b exp 00", {busy, ir_write});
    end
    pulse_start();
    checks++; if ({busy, ir_write} !== 2'b11) begin
      errors++; $display("FAIL start_fetch got %b exp 11", {busy, ir_write});
    end
  endtask

  task automatic test_add();
    instruction = 32'h002081B3;
    tick();
    checks++; if (ctl !== 19'h0) begin errors++; $display("FAIL add_decode got %h exp 0", ctl); end
    tick();
    checks++; if ({alu_op, alu_src_A, alu_src_B, reg_write_en, pc_write} !== 8'b0000_0000) begin
      errors++; $display("FAIL add_exec got %b exp 00000000",
                         {alu_op, alu_src_A, alu_src_B, reg_write_en, pc_write});
    end
    tick();
    checks++; if ({reg_write_en, dest_reg_sel, wb_sel, pc_write, pc_src} !== 7'b11_00_1_00) begin
      errors++; $display("FAIL add_wb got %b exp 1100100",
                         {reg_write_en, dest_reg_sel, wb_sel, pc_write, pc_src});
    end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL add_instret_wb got %0d exp 0", instret); end
    tick();
    exp_instret++;
    checks++; if ({ir_write, instret} !== {1'b1, exp_instret}) begin
      errors++; $display("FAIL add_retire got ir=%b cnt=%0d exp ir=1 cnt=%0d", ir_write, instret, exp_instret);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] ins [7];
    logic [5:0]  exp [7];
    ins = '{32'h402081B3, 32'h0020C1B3, 32'h4020D1B3, 32'h00500093, 32'h4030D093,
            32'h123450B7, 32'h00001097};
    // {alu_op, A, B}: SUB, XOR, SRA, ADDI, SRAI, LUI, AUIPC
    exp = '{6'b0001_00, 6'b0101_00, 6'b0111_00, 6'b0000_01, 6'b0111_01, 6'b1010_01, 6'b0000_11};
    for (int i = 0; i < 7; i++) begin
      instruction = ins[i];
      tick(); tick();
      checks++; if ({alu_op, alu_src_A, alu_src_B} !== exp[i]) begin
        errors++; $display("FAIL alu_exec[%0d] got %b exp %b", i, {alu_op, alu_src_A, alu_src_B}, exp[i]);
      end
      tick();
      checks++; if ({alu_op, alu_src_A, alu_src_B, reg_write_en, pc_write} !== {exp[i], 2'b11}) begin
        errors++; $display("FAIL alu_wb[%0d] got %b exp %b", i,
                           {alu_op, alu_src_A, alu_src_B, reg_write_en, pc_write}, {exp[i], 2'b11});
      end
      tick();
      exp_instret++;
    end
    checks++; if (instret !== exp_instret) begin
      errors++; $display("FAIL alu_instret got %0d exp %0d", instret, exp_instret);
    end
  endtask

  task automatic test_store();
    logic [31:0] ins [4];
    logic [1:0]  addr [4];
    logic [3:0]  we [4];
    logic        any_rw;
    ins  = '{32'h00208023, 32'h00209023, 32'h0020A023, 32'h00208023};
    addr = '{2'd2, 2'd2, 2'd0, 2'd3};
    we   = '{4'b0100, 4'b1100, 4'b1111, 4'b1000};
    any_rw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instruction = ins[i];
      mem_addr_lo = addr[i];
      any_rw |= reg_write_en;
      tick(); any_rw |= reg_write_en;
      tick(); any_rw |= reg_write_en;
      checks++; if ({alu_src_A, alu_src_B, alu_op, mem_write_en} !== 10'b01_0000_0000) begin
        errors++; $display("FAIL store_exec[%0d] got %b exp 0100000000", i,
                           {alu_src_A, alu_src_B, alu_op, mem_write_en});
      end
      tick(); any_rw |= reg_write_en;
      checks++; if ({mem_write_en, pc_write, pc_src} !== {we[i], 3'b100}) begin
        errors++; $display("FAIL store_mem[%0d] got %b exp %b", i,
                           {mem_write_en, pc_write, pc_src}, {we[i], 3'b100});
      end
      tick();
      exp_instret++;
      checks++; if ({ir_write, instret} !== {1'b1, exp_instret}) begin
        errors++; $display("FAIL store_retire[%0d] got ir=%b cnt=%0d exp ir=1 cnt=%0d",
                           i, ir_write, instret, exp_instret);
      end
    end
    checks++; if (any_rw !== 1'b0) begin errors++; $display("FAIL store_no_regwrite got %b exp 0", any_rw); end
    mem_addr_lo = 2'd0;
  endtask

  task automatic test_load();
    instruction = 32'h0000A183;
    mem_addr_lo = 2'd0;
    tick(); tick();
    checks++; if ({read_enable, alu_src_B} !== 2'b01) begin
      errors++; $display("FAIL load_exec got %b exp 01", {read_enable, alu_src_B});
    end
    tick();
    checks++; if ({read_enable, reg_write_en, mem_write_en} !== 6'b10_0000) begin
      errors++; $display("FAIL load_mem got %b exp 100000", {read_enable, reg_write_en, mem_write_en});
    end
    tick();
    checks++; if ({read_enable, reg_write_en, dest_reg_sel, wb_sel, pc_write} !== 6'b0_1_1_01_1) begin
      errors++; $display("FAIL load_wb got %b exp 011011",
                         {read_enable, reg_write_en, dest_reg_sel, wb_sel, pc_write});
    end
    tick();
    exp_instret++;
    checks++; if ({ir_write, instret} !== {1'b1, exp_instret}) begin
      errors++; $display("FAIL load_retire got ir=%b cnt=%0d exp ir=1 cnt=%0d", ir_write, instret, exp_instret);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 2; i++) begin
      instruction = 32'h00208463;
      branch_cond = (i == 0);
      tick(); tick();
      checks++; if ({pc_write, pc_src, alu_src_A, alu_src_B, reg_write_en} !== {1'b1, 1'b0, branch_cond, 3'b110}) begin
        errors++; $display("FAIL branch_exec[%0d] got %b exp %b", i,
                           {pc_write, pc_src, alu_src_A, alu_src_B, reg_write_en}, {1'b1, 1'b0, branch_cond, 3'b110});
      end
      tick();
      exp_instret++;
      checks++; if ({ir_write, instret} !== {1'b1, exp_instret}) begin
        errors++; $display("FAIL branch_retire[%0d] got ir=%b cnt=%0d exp ir=1 cnt=%0d",
                           i, ir_write, instret, exp_instret);
      end
    end
    branch_cond = 1'b0;
  endtask

  task automatic test_jump_fence();
    logic [31:0] ins [3];
    logic [7:0]  exp [3];
    ins = '{32'h000000EF, 32'h000100E7, 32'h0000000F};
    // {reg_write_en, dest_reg_sel, wb_sel, pc_write, pc_src, B}: JAL, JALR, FENCE
    exp = '{8'b1_1_10_1_01_0, 8'b1_1_10_1_10_1, 8'b0_0_00_1_00_0};
    for (int i = 0; i < 3; i++) begin
      instruction = ins[i];
      tick(); tick();
      checks++; if ({reg_write_en, dest_reg_sel, wb_sel, pc_write, pc_src, alu_src_B} !== exp[i]) begin
        errors++; $display("FAIL jump_exec[%0d] got %b exp %b", i,
                           {reg_write_en, dest_reg_sel, wb_sel, pc_write, pc_src, alu_src_B}, exp[i]);
      end
      tick();
      exp_instret++;
      checks++; if ({ir_write, instret} !== {1'b1, exp_instret}) begin
        errors++; $display("FAIL jump_retire[%0d] got ir=%b cnt=%0d exp ir=1 cnt=%0d",
                           i, ir_write, instret, exp_instret);
      end
    end
  endtask

  task automatic test_reset_abort();
    instruction = 32'h0020A023;
    mem_addr_lo = 2'd0;
    tick(); tick(); tick();
    checks++; if (mem_write_en !== 4'b1111) begin
      errors++; $display("FAIL abort_pre got %b exp 1111", mem_write_en);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if ({ctl, busy} !== 20'h0) begin errors++; $display("FAIL abort_async got %h exp 0", {ctl, busy}); end
    tick();
    checks++; if ({ctl, busy, halted, instret} !== 53'h0) begin
      errors++; $display("FAIL abort_held got ctl=%h cnt=%0d exp 0", ctl, instret);
    end
    rst = 1'b1;
    exp_instret = 0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b exp 0", busy); end
    pulse_start();
  endtask

  task automatic test_misaligned();
    logic any_we;
    instruction = 32'h00209023;
    mem_addr_lo = 2'd1;
    any_we = 1'b0;
    tick(); any_we |= |mem_write_en;
    tick(); any_we |= |mem_write_en;
    checks++; if ({busy, halted, alu_src_B} !== 3'b101) begin
      errors++; $display("FAIL misalign_exec got %b exp 101", {busy, halted, alu_src_B});
    end
    tick(); any_we |= |mem_write_en;
    checks++; if ({halted, illegal, busy, instret} !== {3'b110, exp_instret}) begin
      errors++; $display("FAIL misalign_halt got h=%b i=%b b=%b cnt=%0d exp 1 1 0 %0d",
                         halted, illegal, busy, instret, exp_instret);
    end
    pulse_start(); any_we |= |mem_write_en;
    tick(); any_we |= |mem_write_en;
    checks++; if ({halted, ir_write, pc_write, reg_write_en} !== 4'b1000) begin
      errors++; $display("FAIL misalign_absorb got %b exp 1000", {halted, ir_write, pc_write, reg_write_en});
    end
    checks++; if (any_we !== 1'b0) begin errors++; $display("FAIL misalign_no_we got %b exp 0", any_we); end
    mem_addr_lo = 2'd0;
    restart();
    checks++; if ({illegal, halted, ir_write} !== 3'b001) begin
      errors++; $display("FAIL misalign_cleared got %b exp 001", {illegal, halted, ir_write});
    end
  endtask

  task automatic test_ebreak();
    instruction = 32'h00100073;
    tick(); tick();
    checks++; if ({halted, illegal, busy} !== 3'b100) begin
      errors++; $display("FAIL ebreak_halt got %b exp 100", {halted, illegal, busy});
    end
    pulse_start();
    tick();
    checks++; if ({halted, busy, ctl} !== {2'b10, 19'h0}) begin
      errors++; $display("FAIL ebreak_start_ignored got h=%b b=%b ctl=%h exp 1 0 0", halted, busy, ctl);
    end
    restart();
  endtask

  task automatic test_illegal();
    logic [31:0] ins [3];
    ins = '{32'h0000007F, 32'h022081B3, 32'h4020C1B3};
    for (int i = 0; i < 3; i++) begin
      instruction = ins[i];
      tick(); tick();
      checks++; if ({halted, illegal, reg_write_en, instret} !== {3'b110, exp_instret}) begin
        errors++; $display("FAIL illegal[%0d] got h=%b i=%b rw=%b cnt=%0d exp 1 1 0 %0d",
                           i, halted, illegal, reg_write_en, instret, exp_instret);
      end
      restart();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_store();
    test_load();
    test_branch();
    test_jump_fence();
    test_reset_abort();
    test_misaligned();
    test_ebreak();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
